mem_ctrl_requester: RTL
=======================

MEM_CTRL_REQUESTER -- requirements
Module: mem_ctrl_requester

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 20; line address width in 256-bit lines.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4; maximum number of reads in flight (1..15).
REQ-003 SHALL have one clock and a synchronous, active-high reset; ports clk and rst.
REQ-004 Port list (clock and reset first):
- clk  in  1  sole clock; all logic on posedge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  client request valid
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_we  in  1  1 = write line, 0 = read line
- req_addr  in  ADDR_WIDTH  line address
- req_wdata  in  256  write line; [127:0] low half
- rsp_valid  out  1  read line available
- rsp_ready  in  1  client takes the line
- rsp_rdata  out  256  assembled read line
- mc_address  out  ADDR_WIDTH  address-FIFO entry
- mc_read  out  1  command type, 1 = read
- mc_writeaf  out  1  push address FIFO
- mc_affull  in  1  address FIFO full
- mc_writedata  out  128  write-buffer beat
- mc_writewb  out  1  push write buffer
- mc_wbfull  in  1  write buffer full
- mc_readdata  in  128  read-buffer head beat
- mc_rbempty  in  1  read buffer empty
- mc_readrb  out  1  pop read buffer
- stat_rd  out  32  completed-read count
- stat_wr  out  32  issued-write count

Function
REQ-005 Command FSM SHALL have states IDLE, WR_LO, WR_HI, CMD.
REQ-006 req_ready SHALL be high only in IDLE, and for reads only when the outstanding count < MAX_OUTSTANDING.
REQ-007 On acceptance, addr, we and wdata SHALL be registered; a write goes to WR_LO, a read goes to CMD.
REQ-008 WR_LO: when mc_wbfull=0, SHALL assert mc_writewb with wdata[127:0] and go to WR_HI; otherwise SHALL hold with mc_writewb=0.
REQ-009 WR_HI: same as WR_LO with wdata[255:128], then go to CMD.
REQ-010 CMD: when mc_affull=0, SHALL assert mc_writeaf for exactly one cycle with mc_read = registered type, then go to IDLE; otherwise SHALL hold.
REQ-011 mc_address SHALL equal the registered address in WR_LO, WR_HI and CMD.
REQ-012 mc_writeaf and mc_writewb SHALL each be high for at most one cycle per beat and SHALL never be high together.
REQ-013 Minimum turnaround SHALL be: read 2 cycles accept-to-next-accept; write 4 cycles.
REQ-014 Return path SHALL pop (mc_readrb=1) when mc_rbempty=0 and the line assembler is not holding a full line.
- First beat SHALL go to rsp_rdata[127:0]; second beat to [255:128].
- rsp_valid SHALL assert the cycle after the second pop.
REQ-015 rsp_valid SHALL hold, with rsp_rdata stable, until rsp_ready is sampled high; no pop SHALL occur while a full line is held.
REQ-016 Outstanding count SHALL increment on the CMD issue of a read and decrement on the rsp_valid&rsp_ready handshake; if both occur in the same cycle, the count SHALL be unchanged.
REQ-017 The outstanding count SHALL never wrap; a beat arriving with count 0 SHALL still be assembled. This is a protocol error and is not flagged.
REQ-018 Writes SHALL NOT be blocked by outstanding reads.
REQ-019 Read responses SHALL return in issue order.

Reset
REQ-020 On rst: FSM to IDLE; outstanding count 0; beat select low; rsp_valid 0; rsp_rdata 0; all mc_* strobes 0; mc_address 0; stat_rd and stat_wr 0.
REQ-021 Reset during WR_LO, WR_HI or CMD SHALL abandon the request with no further strobes; in-flight read data arriving after reset SHALL be popped and assembled as new lines.

Configuration
REQ-022 Macro MEMREQ_STATS_EN:
- Defined: stat_rd SHALL increment per rsp handshake and stat_wr per write CMD issue, wrapping at 2^32.
- Undefined: both outputs SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-023 Write addr 0x00010, wdata {128'hB..., 128'hA...}, full signals low -> mc_writewb at cycles 1 and 2 with A then B; mc_writeaf, mc_read=0 at cycle 3; req_ready high again at cycle 4.
REQ-024 Read addr 0x00020, model returns beats 0x11.., 0x22.. -> rsp_rdata = {0x22.., 0x11..}; rsp_valid one cycle after the second pop.
REQ-025 Five back-to-back reads, MAX_OUTSTANDING=4, no data returned -> four issued; req_ready low until the first rsp handshake.
REQ-026 mc_wbfull=1 for 3 cycles in WR_HI -> mc_writewb withheld for 3 cycles; high-half beat issued when mc_wbfull drops; exactly two beats total.
REQ-027 rsp_ready=0 for 5 cycles with 4 beats queued -> exactly 2 pops; rsp_rdata stable; remaining pops resume after the handshake.
REQ-028 MEMREQ_STATS_EN defined: 3 writes and 2 completed reads -> stat_wr=3, stat_rd=2; rst -> both 0.

Source files
------------

// File: rtl/mem_ctrl_requester.sv
// Line requester: turns 256-bit line reads/writes into 128-bit memory-controller
// FIFO traffic and reassembles read lines. Optional counters: define MEMREQ_STATS_EN.
module mem_ctrl_requester #(
   parameter int ADDR_WIDTH      = 20,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [255:0]          req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [255:0]          rsp_rdata,
   output logic [ADDR_WIDTH-1:0] mc_address,
   output logic                  mc_read,
   output logic                  mc_writeaf,
   input  logic                  mc_affull,
   output logic [127:0]          mc_writedata,
   output logic                  mc_writewb,
   input  logic                  mc_wbfull,
   input  logic [127:0]          mc_readdata,
   input  logic                  mc_rbempty,
   output logic                  mc_readrb,
   output logic [31:0]           stat_rd,
   output logic [31:0]           stat_wr
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WR_LO = 2'd1,
      WR_HI = 2'd2,
      CMD   = 2'd3
   } state_t;

   localparam logic [3:0] MAX_C = 4'(MAX_OUTSTANDING);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  we_q, we_d;
   logic [255:0]          wdata_q, wdata_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  sel_q, sel_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [255:0]          rdata_q, rdata_d;
   logic                  ready_s;
   logic                  issue_rd_s;
   logic                  pop_s;
   logic                  hs_s;
   logic                  dec_s;

   // Writes never wait on the read budget; reads stall once MAX_OUTSTANDING are in flight.
   assign ready_s    = (state_q == IDLE) && !rst && (req_we || (cnt_q < MAX_C));
   assign req_ready  = ready_s;
   assign mc_address = addr_q;

   // Command FSM next state and strobes; strobes are forced low while rst is high.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      we_d         = we_q;
      wdata_d      = wdata_q;
      mc_writewb   = 1'b0;
      mc_writedata = wdata_q[127:0];
      mc_writeaf   = 1'b0;
      mc_read      = 1'b0;
      issue_rd_s   = 1'b0;
      if (rst) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid && ready_s) begin
                  addr_d  = req_addr;
                  we_d    = req_we;
                  wdata_d = req_wdata;
                  state_d = req_we ? WR_LO : CMD;
               end else begin
                  state_d = IDLE;
               end
            end
            WR_LO: begin
               if (!mc_wbfull) begin
                  mc_writewb = 1'b1;
                  state_d    = WR_HI;
               end else begin
                  state_d = WR_LO;
               end
            end
            WR_HI: begin
               mc_writedata = wdata_q[255:128];
               if (!mc_wbfull) begin
                  mc_writewb = 1'b1;
                  state_d    = CMD;
               end else begin
                  state_d = WR_HI;
               end
            end
            CMD: begin
               if (!mc_affull) begin
                  mc_writeaf = 1'b1;
                  mc_read    = !we_q;
                  issue_rd_s = !we_q;
                  state_d    = IDLE;
               end else begin
                  state_d = CMD;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Command-side registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= {ADDR_WIDTH{1'b0}};
         we_q    <= 1'b0;
         wdata_q <= 256'd0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
      end
   end

   // A held line blocks further pops, so pop and handshake are mutually exclusive.
   assign pop_s     = !rst && !mc_rbempty && !rsp_valid_q;
   assign hs_s      = rsp_valid_q && rsp_ready;
   assign mc_readrb = pop_s;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;

   // Line assembler: low beat first, line presented the cycle after the high beat.
   always_comb begin
      sel_d       = sel_q;
      rdata_d     = rdata_q;
      rsp_valid_d = rsp_valid_q;
      if (pop_s) begin
         if (!sel_q) begin
            rdata_d[127:0] = mc_readdata;
            sel_d          = 1'b1;
         end else begin
            rdata_d[255:128] = mc_readdata;
            sel_d            = 1'b0;
            rsp_valid_d      = 1'b1;
         end
      end else if (hs_s) begin
         rsp_valid_d = 1'b0;
      end else begin
         rsp_valid_d = rsp_valid_q;
      end
   end

   // A response with nothing outstanding is still delivered but must not wrap the count.
   assign dec_s = hs_s && (cnt_q != 4'd0);

   // Outstanding-read count.
   always_comb begin
      cnt_d = cnt_q;
      case ({issue_rd_s, dec_s})
         2'b10: begin
            if (cnt_q != 4'hF) begin
               cnt_d = cnt_q + 4'd1;
            end else begin
               cnt_d = cnt_q;
            end
         end
         2'b01:   cnt_d = cnt_q - 4'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Return-path registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= 4'd0;
         sel_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= 256'd0;
      end else begin
         cnt_q       <= cnt_d;
         sel_q       <= sel_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
      end
   end

`ifdef MEMREQ_STATS_EN
   logic [31:0] stat_rd_q;
   logic [31:0] stat_wr_q;

   // Free-running statistics, wrapping at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_rd_q <= 32'd0;
         stat_wr_q <= 32'd0;
      end else begin
         if (hs_s) begin
            stat_rd_q <= stat_rd_q + 32'd1;
         end
         if (mc_writeaf && !mc_read) begin
            stat_wr_q <= stat_wr_q + 32'd1;
         end
      end
   end

   assign stat_rd = stat_rd_q;
   assign stat_wr = stat_wr_q;
`else
   assign stat_rd = 32'd0;
   assign stat_wr = 32'd0;
`endif

endmodule
